// File: rtl/maint_log_if.sv
// Bundle between the maintenance event source / diagnostic port and the
// circular maintenance log.
interface maint_log_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 11
);
   logic              clear;
   logic              log_valid;
   logic [DATA_W-1:0] log_data;
   logic              log_ready;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_index;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              rd_err;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              overflow;

   modport master (
      output clear, log_valid, log_data, rd_en, rd_index,
      input  log_ready, rd_valid, rd_data, rd_err, count, full, overflow
   );

   modport slave (
      input  clear, log_valid, log_data, rd_en, rd_index,
      output log_ready, rd_valid, rd_data, rd_err, count, full, overflow
   );
endinterface

// File: rtl/maint_log_buffer.sv
// Circular maintenance-event log: wrap or stop-when-full storage with
// oldest-relative read-back, occupancy and sticky overflow status.
module maint_log_buffer #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 11,
   parameter bit WRAP_MODE = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   maint_log_if.slave  bus
);
   localparam int              DEPTH   = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [DATA_W-1:0] ram_q_r;
   logic [ADDR_W-1:0] wr_ptr_r;
   logic [ADDR_W:0]   count_r;
   logic              full_r;
   logic              overflow_r;
   logic              rd_valid_r;
   logic              rd_err_r;
   logic              rd_hit_r;

   logic              log_ready_s;
   logic              wr_en_s;
   logic [ADDR_W-1:0] oldest_s;
   logic [ADDR_W-1:0] rd_addr_s;
   logic              rd_hit_s;
   logic [ADDR_W-1:0] wr_ptr_next_s;
   logic [ADDR_W:0]   count_next_s;
   logic              overflow_next_s;

   assign log_ready_s = !bus.clear && ((WRAP_MODE == 1'b1) || !full_r);
   assign wr_en_s     = bus.log_valid && log_ready_s;
   // With count == DEPTH the low bits of count are zero, so oldest == wr_ptr.
   assign oldest_s    = wr_ptr_r - count_r[ADDR_W-1:0];
   assign rd_addr_s   = oldest_s + bus.rd_index;
   assign rd_hit_s    = ({1'b0, bus.rd_index} < count_r);

   // Next pointer, occupancy and overflow; clear wins over a same-cycle write
   always_comb begin
      wr_ptr_next_s   = wr_ptr_r;
      count_next_s    = count_r;
      overflow_next_s = overflow_r;
      if (bus.clear) begin
         wr_ptr_next_s   = {ADDR_W{1'b0}};
         count_next_s    = {(ADDR_W+1){1'b0}};
         overflow_next_s = 1'b0;
      end else begin
         if (wr_en_s) begin
            wr_ptr_next_s = wr_ptr_r + ADDR_W'(1);
            if (full_r) begin
               count_next_s = count_r;
            end else begin
               count_next_s = count_r + (ADDR_W+1)'(1);
            end
         end else begin
            wr_ptr_next_s = wr_ptr_r;
            count_next_s  = count_r;
         end
         if (bus.log_valid && full_r) begin
            overflow_next_s = 1'b1;
         end else begin
            overflow_next_s = overflow_r;
         end
      end
   end

   // Log state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_r   <= {ADDR_W{1'b0}};
         count_r    <= {(ADDR_W+1){1'b0}};
         full_r     <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         wr_ptr_r   <= wr_ptr_next_s;
         count_r    <= count_next_s;
         full_r     <= (count_next_s == DEPTH_C);
         overflow_r <= overflow_next_s;
      end
   end

   // Record RAM: one write port, one synchronous read-before-write port
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r] <= bus.log_data;
      end
      if (bus.rd_en) begin
         ram_q_r <= mem_r[rd_addr_s];
      end
   end

   // Read response flags; err/hit hold between requests
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_valid_r <= 1'b0;
         rd_err_r   <= 1'b0;
         rd_hit_r   <= 1'b0;
      end else begin
         rd_valid_r <= bus.rd_en;
         if (bus.rd_en) begin
            rd_err_r <= !rd_hit_s;
            rd_hit_r <= rd_hit_s;
         end
      end
   end

   assign bus.log_ready = log_ready_s;
   assign bus.rd_valid  = rd_valid_r;
   assign bus.rd_err    = rd_err_r;
   assign bus.rd_data   = rd_hit_r ? ram_q_r : {DATA_W{1'b0}};
   assign bus.count     = count_r;
   assign bus.full      = full_r;
   assign bus.overflow  = overflow_r;
endmodule

// File: tb/tb_maint_log_buffer.sv
// Runs a wrap-mode and a stop-when-full log side by side against a queue
// model, with read responses checked through a scoreboard.
module tb_maint_log_buffer;
   logic clk;
   logic reset;

   maint_log_if #(.DATA_W(8), .ADDR_W(2)) bw ();
   maint_log_if #(.DATA_W(8), .ADDR_W(2)) bn ();

   maint_log_buffer #(.DATA_W(8), .ADDR_W(2), .WRAP_MODE(1'b1)) u_wrap (
      .clk   (clk),
      .reset (reset),
      .bus   (bw)
   );

   maint_log_buffer #(.DATA_W(8), .ADDR_W(2), .WRAP_MODE(1'b0)) u_stop (
      .clk   (clk),
      .reset (reset),
      .bus   (bn)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total_cnt = 0;
   int pass_cnt  = 0;

   logic [7:0] qw [$];
   logic [7:0] qn [$];
   logic       ovw;
   logic       ovn;
   logic [8:0] sbw [$];
   logic [8:0] sbn [$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic c,
                        input logic r, input logic [1:0] idx);
      bw.log_valid = v; bw.log_data = d; bw.clear = c; bw.rd_en = r; bw.rd_index = idx;
      bn.log_valid = v; bn.log_data = d; bn.clear = c; bn.rd_en = r; bn.rd_index = idx;
   endtask

   task automatic check_status();
      logic [8:0] e;
      if (bw.rd_valid) begin
         if (sbw.size() == 0) begin
            check_eq("wrap_unexpected_rd_valid", 32'd1, 32'd0);
         end else begin
            e = sbw.pop_front();
            check_eq("wrap_rd_err", bw.rd_err, e[8]);
            check_eq("wrap_rd_data", bw.rd_data, e[7:0]);
         end
      end
      if (bn.rd_valid) begin
         if (sbn.size() == 0) begin
            check_eq("stop_unexpected_rd_valid", 32'd1, 32'd0);
         end else begin
            e = sbn.pop_front();
            check_eq("stop_rd_err", bn.rd_err, e[8]);
            check_eq("stop_rd_data", bn.rd_data, e[7:0]);
         end
      end
      check_eq("wrap_count", bw.count, qw.size());
      check_eq("stop_count", bn.count, qn.size());
      check_eq("wrap_full", bw.full, qw.size() == 4);
      check_eq("stop_full", bn.full, qn.size() == 4);
      check_eq("wrap_overflow", bw.overflow, ovw);
      check_eq("stop_overflow", bn.overflow, ovn);
   endtask

   // One clock cycle of stimulus: predict, push expectations, then observe
   task automatic cyc(input logic v, input logic [7:0] d, input logic c,
                      input logic r, input logic [1:0] idx);
      logic [7:0] tmp;
      drive(v, d, c, r, idx);
      #1;
      check_eq("wrap_log_ready", bw.log_ready, !c);
      check_eq("stop_log_ready", bn.log_ready, !c && (qn.size() < 4));
      if (r) begin
         if (int'(idx) < qw.size()) sbw.push_back({1'b0, qw[idx]});
         else                       sbw.push_back(9'h100);
         if (int'(idx) < qn.size()) sbn.push_back({1'b0, qn[idx]});
         else                       sbn.push_back(9'h100);
      end
      if (c) begin
         qw.delete(); qn.delete(); ovw = 1'b0; ovn = 1'b0;
      end else if (v) begin
         if (qw.size() == 4) begin
            tmp = qw.pop_front();
            ovw = 1'b1;
         end
         qw.push_back(d);
         if (qn.size() == 4) ovn = 1'b1;
         else                qn.push_back(d);
      end
      @(posedge clk); #1;
      check_eq("wrap_rd_valid", bw.rd_valid, r);
      check_eq("stop_rd_valid", bn.rd_valid, r);
      check_status();
   endtask

   task automatic mid_reset();
      drive(1'b0, 8'h00, 1'b0, 1'b1, 2'd0);
      reset = 1'b0;
      qw.delete(); qn.delete(); ovw = 1'b0; ovn = 1'b0;
      sbw.delete(); sbn.delete();
      #1;
      @(posedge clk); #1;
      check_eq("reset_wrap_rd_valid", bw.rd_valid, 1'b0);
      check_eq("reset_stop_rd_valid", bn.rd_valid, 1'b0);
      check_eq("reset_wrap_rd_data", bw.rd_data, 8'h00);
      check_eq("reset_wrap_rd_err", bw.rd_err, 1'b0);
      check_status();
      drive(1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      check_status();
   endtask

   initial begin
      ovw = 1'b0; ovn = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_rd_valid", bw.rd_valid, 1'b0);
      check_eq("reset_rd_data", bw.rd_data, 8'h00);
      check_eq("reset_stop_rd_err", bn.rd_err, 1'b0);
      check_status();
      reset = 1'b1;
      @(posedge clk); #1;

      // basic write and read back, including an unpopulated index
      cyc(1'b1, 8'h11, 1'b0, 1'b0, 2'd0);
      cyc(1'b1, 8'h22, 1'b0, 1'b0, 2'd0);
      cyc(1'b1, 8'h33, 1'b0, 1'b0, 2'd0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'(i));

      // overfill: wrap keeps newest four, stop keeps first four
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'd0);
      for (int i = 1; i <= 6; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 2'd0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'(i));

      // same-cycle write and read of the oldest slot while full
      cyc(1'b1, 8'hAA, 1'b0, 1'b1, 2'd0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'd3);

      // clear beats a same-cycle write; read in that cycle sees pre-clear state
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'd0);
      cyc(1'b1, 8'h5A, 1'b0, 1'b0, 2'd0);
      cyc(1'b1, 8'hA5, 1'b0, 1'b0, 2'd0);
      cyc(1'b1, 8'hEE, 1'b1, 1'b1, 2'd1);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'd0);
      cyc(1'b1, 8'h55, 1'b0, 1'b0, 2'd0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'd0);

      // reset dropped mid-sequence with a read in flight
      cyc(1'b1, 8'h61, 1'b0, 1'b0, 2'd0);
      cyc(1'b1, 8'h62, 1'b0, 1'b0, 2'd0);
      mid_reset();
      cyc(1'b1, 8'h77, 1'b0, 1'b1, 2'd0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'd0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'd1);

      for (int i = 0; i < 80; i++) begin
         cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)));
      end

      check_eq("wrap_scoreboard_drained", sbw.size(), 0);
      check_eq("stop_scoreboard_drained", sbn.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
